seed_key_sched_ctrl: RTL and testbench

Sequencer that drives the SEED-128 round-key generator. It loads a 128-bit user key into the generator and steps the round index 0..ROUNDS-1. It captures each 64-bit round key into an internal buffer and exposes the buffer through an indexed read port. The SEED encrypt/decrypt round engine reads round keys from this buffer, so it is decoupled from key-generator timing and can run decryption in reverse order.

---
 rtl/seed_key_sched_ctrl.sv | 133 +++++++++++++
 tb/tb_seed_key_sched_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_key_sched_ctrl.sv
// SEED-128 key-schedule sequencer: loads the user key into the round-key generator,
// steps the round index and captures each round key into an indexed read buffer.
module seed_key_sched_ctrl #(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned KW     = 64
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Start,
  input  logic          i_Abort,
  input  logic [127:0]  i_Key,
  output logic          o_KgStart,
  output logic [127:0]  o_KgKey,
  output logic [3:0]    o_KgRound,
  input  logic [KW-1:0] i_KgKey,
  input  logic [3:0]    i_RdRound,
  output logic [KW-1:0] o_RdKey,
  output logic          o_Busy,
  output logic          o_Done,
  output logic          o_KeyValid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_GEN
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            kg_start_q;
  logic [127:0]    key_q;
  logic            busy_q;
  logic            done_q;
  logic            valid_q;
  logic [KW-1:0]   buf_q [16];
  logic [KW-1:0]   rd_q;
  logic            wr_en;
  logic            rd_in_range;

  // Abort suppresses the write on its own edge so the buffer keeps its stale contents.
  always_comb begin
    wr_en       = 1'b0;
    rd_in_range = 1'b0;
    if (state_q == S_GEN && !i_Abort) begin
      wr_en = 1'b1;
    end
    if (32'(i_RdRound) < ROUNDS) begin
      rd_in_range = 1'b1;
    end
  end

  // Counter doubles as the generator round index; it is held at 0 outside GEN.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kg_start_q <= 1'b0;
      key_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      kg_start_q <= 1'b0;
      if (i_Abort) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_Start) begin
              key_q      <= i_Key;
              valid_q    <= 1'b0;
              busy_q     <= 1'b1;
              kg_start_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= S_LOAD;
            end
          end
          S_LOAD: begin
            cnt_q   <= '0;
            state_q <= S_GEN;
          end
          S_GEN: begin
            if (cnt_q == LAST_ROUND) begin
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          default: begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Read samples the pre-edge array contents, giving read-before-write on a shared index.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int unsigned i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (wr_en) begin
        buf_q[cnt_q] <= i_KgKey;
      end
      rd_q <= rd_in_range ? buf_q[i_RdRound] : '0;
    end
  end

  assign o_KgStart  = kg_start_q;
  assign o_KgKey    = key_q;
  assign o_KgRound  = cnt_q;
  assign o_RdKey    = rd_q;
  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign o_KeyValid = valid_q;

endmodule

// File: tb/tb_seed_key_sched_ctrl.sv
// Bench for seed_key_sched_ctrl: a stand-in round-key generator feeds the DUT, and a
// scoreboard queue holds expected buffer reads pushed as each read index is driven.
module tb_seed_key_sched_ctrl;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_Start;
  logic          i_Abort;
  logic [127:0]  i_Key;
  logic          kg_start;
  logic [127:0]  kg_key;
  logic [3:0]    kg_round;
  logic [63:0]   kg_rk;
  logic [3:0]    rd_idx;
  logic [63:0]   rd_key;
  logic          busy;
  logic          done;
  logic          kvalid;

  logic          s_kg_start;
  logic [127:0]  s_kg_key;
  logic [3:0]    s_kg_round;
  logic [63:0]   s_rd_key;
  logic          s_busy;
  logic          s_done;
  logic          s_kvalid;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [63:0]   exp_buf [16];
  logic [63:0]   exp_q [$];
  logic [127:0]  gen_key;

  always #5 clk = ~clk;

  seed_key_sched_ctrl #(.ROUNDS(16), .KW(64)) u_dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_Start(i_Start), .i_Abort(i_Abort), .i_Key(i_Key),
    .o_KgStart(kg_start), .o_KgKey(kg_key), .o_KgRound(kg_round), .i_KgKey(kg_rk),
    .i_RdRound(rd_idx), .o_RdKey(rd_key), .o_Busy(busy), .o_Done(done), .o_KeyValid(kvalid)
  );

  // Shorter schedule instance: indices at or above 12 must read back as zero.
  seed_key_sched_ctrl #(.ROUNDS(12), .KW(64)) u_dut12 (
    .i_Clk(clk), .i_Rst(rst_n), .i_Start(i_Start), .i_Abort(i_Abort), .i_Key(i_Key),
    .o_KgStart(s_kg_start), .o_KgKey(s_kg_key), .o_KgRound(s_kg_round), .i_KgKey(kg_rk),
    .i_RdRound(rd_idx), .o_RdKey(s_rd_key), .o_Busy(s_busy), .o_Done(s_done), .o_KeyValid(s_kvalid)
  );

  function automatic logic [63:0] gen_fn(input logic [127:0] k, input logic [3:0] r);
    logic [63:0] a;
    logic [63:0] b;
    int unsigned s;
    a = k[127:64];
    b = k[63:0];
    s = 4 * int'(r) + 3;
    return a ^ ((b << s) | (b >> (64 - s))) ^ (64'h9E3779B97F4A7C15 * 64'(int'(r) + 1));
  endfunction

  // Stand-in generator: loads on the start strobe, output combinational from state and round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gen_key <= '0;
    else if (kg_start) gen_key <= kg_key;
  end
  assign kg_rk = gen_fn(gen_key, kg_round);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic read_check(input string nm);
    logic [63:0] e;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (rd_key !== e) begin
          n_err++;
          $display("FAIL %s[%0d]: got %h expected %h", nm, i - 1, rd_key, e);
        end
      end
      if (i < 16) begin
        rd_idx = 4'(i);
        exp_q.push_back(exp_buf[i]);
      end
    end
  endtask

  // One schedule in lockstep; optional ignored start at inj_at, abort/reset at stop_at.
  task automatic run_sched(input logic [127:0] key, input int inj_at, input int stop_at,
                           input bit by_reset, input string nm);
    logic [63:0] e;
    @(negedge clk);
    i_Start = 1'b1;
    i_Key   = key;
    @(negedge clk);
    i_Start = 1'b0;
    n_cmp++;
    if ({busy, kg_start, kg_round, kvalid, done} !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s_load: busy/kgstart/round/valid/done=%b expected 1_1_0000_0_0", nm,
               {busy, kg_start, kg_round, kvalid, done});
    end
    n_cmp++;
    if (kg_key !== key) begin
      n_err++;
      $display("FAIL %s_latch: kgkey=%h expected %h", nm, kg_key, key);
    end
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      i_Start = 1'b0;
      n_cmp++;
      if ({busy, kg_start, kg_round, kvalid, done} !== {1'b1, 1'b0, 4'(r), 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL %s_gen[%0d]: busy/kgstart/round/valid/done=%b expected 1_0_%b_0_0", nm, r,
                 {busy, kg_start, kg_round, kvalid, done}, 4'(r));
      end
      if (r == inj_at) begin
        i_Start = 1'b1;
        i_Key   = ~key;
      end
      if (r == 15) begin
        rd_idx = 4'd15;
        exp_q.push_back(exp_buf[15]);
      end
      if (r == stop_at) begin
        if (by_reset) begin
          #2 rst_n = 1'b0;
          #1;
          n_cmp++;
          if ({kg_start, kg_key, kg_round, rd_key, busy, done, kvalid} !== '0) begin
            n_err++;
            $display("FAIL %s_async_rst: kgstart=%b kgkey=%h round=%h rdkey=%h busy=%b done=%b valid=%b expected all 0",
                     nm, kg_start, kg_key, kg_round, rd_key, busy, done, kvalid);
          end
          @(negedge clk);
          rst_n = 1'b1;
          for (int j = 0; j < 16; j++) exp_buf[j] = '0;
        end else begin
          i_Abort = 1'b1;
          @(negedge clk);
          i_Abort = 1'b0;
          n_cmp++;
          if ({busy, kg_start, kg_round, kvalid, done} !== 8'b0) begin
            n_err++;
            $display("FAIL %s_abort: busy/kgstart/round/valid/done=%b expected all 0", nm,
                     {busy, kg_start, kg_round, kvalid, done});
          end
          for (int j = 0; j < r; j++) exp_buf[j] = gen_fn(key, 4'(j));
          @(negedge clk);
          n_cmp++;
          if ({busy, done, kvalid} !== 3'b000) begin
            n_err++;
            $display("FAIL %s_abort_idle: busy/done/valid=%b expected 000", nm, {busy, done, kvalid});
          end
        end
        return;
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, kg_start, kg_round, kvalid, done} !== {1'b0, 1'b0, 4'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL %s_done: busy/kgstart/round/valid/done=%b expected 0_0_0000_1_1", nm,
               {busy, kg_start, kg_round, kvalid, done});
    end
    n_cmp++;
    if (kg_key !== key) begin
      n_err++;
      $display("FAIL %s_key_stable: kgkey=%h expected %h", nm, kg_key, key);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_key !== e) begin
      n_err++;
      $display("FAIL %s_rbw_old: got %h expected %h", nm, rd_key, e);
    end
    for (int j = 0; j < 16; j++) exp_buf[j] = gen_fn(key, 4'(j));
    exp_q.push_back(exp_buf[15]);
    @(negedge clk);
    n_cmp++;
    if ({done, kvalid} !== 2'b01) begin
      n_err++;
      $display("FAIL %s_done_pulse: done/valid=%b expected 01", nm, {done, kvalid});
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_key !== e) begin
      n_err++;
      $display("FAIL %s_rbw_new: got %h expected %h", nm, rd_key, e);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_Start = 1'b0;
    i_Abort = 1'b0;
    i_Key   = '0;
    rd_idx  = '0;
    for (int j = 0; j < 16; j++) exp_buf[j] = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({kg_start, kg_key, kg_round, rd_key, busy, done, kvalid} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: kgstart=%b kgkey=%h round=%h rdkey=%h busy=%b done=%b valid=%b expected all 0",
               kg_start, kg_key, kg_round, rd_key, busy, done, kvalid);
    end
    rst_n = 1'b1;
    read_check("reset_buf");
  endtask

  task automatic test_basic();
    run_sched(128'h0, -1, -1, 1'b0, "basic");
    read_check("basic_rd");
  endtask

  task automatic test_out_of_range();
    logic [63:0] e;
    logic [63:0] q12 [$];
    for (int i = 10; i <= 16; i++) begin
      @(negedge clk);
      if (i > 10) begin
        e = q12.pop_front();
        n_cmp++;
        if (s_rd_key !== e) begin
          n_err++;
          $display("FAIL r12_rd[%0d]: got %h expected %h", i - 1, s_rd_key, e);
        end
      end
      if (i < 16) begin
        rd_idx = 4'(i);
        q12.push_back((i < 12) ? gen_fn(128'h0, 4'(i)) : 64'h0);
      end
    end
  endtask

  task automatic test_ignored_start();
    run_sched(128'h0123456789ABCDEF_FEDCBA9876543210, 3, -1, 1'b0, "busy_start");
    read_check("busy_start_rd");
  endtask

  task automatic test_abort();
    run_sched(128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D, -1, 7, 1'b0, "abort");
    read_check("abort_stale_rd");
    run_sched(128'h11112222_33334444_55556666_77778888, -1, -1, 1'b0, "post_abort");
    read_check("post_abort_rd");
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    i_Start = 1'b1;
    i_Abort = 1'b1;
    i_Key   = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    @(negedge clk);
    i_Start = 1'b0;
    i_Abort = 1'b0;
    n_cmp++;
    if ({busy, kg_start, kvalid, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_start: busy/kgstart/valid/done=%b expected 0000", {busy, kg_start, kvalid, done});
    end
    n_cmp++;
    if (kg_key !== 128'h11112222_33334444_55556666_77778888) begin
      n_err++;
      $display("FAIL abort_start_key: kgkey=%h expected 11112222333344445555666677778888", kg_key);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, kg_start} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_start_idle: busy/kgstart=%b expected 00", {busy, kg_start});
    end
  endtask

  task automatic test_back_to_back();
    run_sched(128'h00000000_00000001_00000000_00000002, -1, -1, 1'b0, "b2b_a");
    run_sched(128'h80000000_00000000_00000000_00000003, -1, -1, 1'b0, "b2b_b");
    read_check("b2b_rd");
  endtask

  task automatic test_reset_midgen();
    run_sched(128'hCAFEBABE_0BADF00D_12345678_9ABCDEF0, -1, 5, 1'b1, "midrst");
    read_check("midrst_rd");
    run_sched(128'h0F0F0F0F_F0F0F0F0_3C3C3C3C_C3C3C3C3, -1, -1, 1'b0, "recover");
    read_check("recover_rd");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_range();
    test_ignored_start();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    test_reset_midgen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
